i8088_bus_responder: RTL and testbench

//  Peripheral-side slave for the 8088 min-mode local bus; answers cycles issued on the Intel8088Pins interface.

---
 rtl/i8088_bus_responder.sv | 137 +++++++++++++
 tb/tb_i8088_bus_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/i8088_bus_responder.sv
// 8088 min-mode local-bus slave: latches address on ALE, claims a decoded window, backs it with byte RAM.
// Optional macro READY_WAIT_EN adds a WAIT state that holds READY low for WAIT_STATES cycles.
module i8088_bus_responder #(
   parameter int          IS_IO       = 0,
   parameter logic [19:0] BASE_ADDR   = 20'h0,
   parameter int          ADDR_BITS   = 10,
   parameter int          WAIT_STATES = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ALE,
   input  logic        IOM,
   input  logic        RD,
   input  logic        WR,
   input  logic [11:0] A,
   inout  logic [7:0]  AD,
   output logic        READY,
   output logic        SEL
);

   localparam int          DEPTH    = 1 << ADDR_BITS;
   localparam logic [19:0] WIN_MASK = ~((20'h1 << ADDR_BITS) - 20'h1);
   // IO space only decodes A15..A0, so the upper nibble is excluded from the compare.
   localparam logic [19:0] CMP_MASK = (IS_IO != 0) ? (WIN_MASK & 20'h0FFFF) : WIN_MASK;

`ifdef READY_WAIT_EN
   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_WAIT, ST_DATA} state_t;
   logic [3:0] cnt, cnt_nxt;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;
`endif

   state_t                 state, state_nxt;
   logic [ADDR_BITS-1:0]   off_p0;
   logic [7:0]             wdat_p0;
   logic                   wr_q;
   logic [7:0]             ram [DEPTH];

   logic [19:0] bus_addr;
   logic        hit, rd_act, wr_act, both_low, bus_idle, ram_we, rd_drive;

   assign bus_addr = {A, AD};
   assign hit      = (IOM == (IS_IO != 0)) && (((bus_addr ^ BASE_ADDR) & CMP_MASK) == 20'h0);
   assign rd_act   = !RD &&  WR;
   assign wr_act   =  RD && !WR;
   assign both_low = !RD && !WR;
   assign bus_idle =  RD &&  WR;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= ST_IDLE;
         wr_q  <= 1'b1;
`ifdef READY_WAIT_EN
         cnt   <= 4'd0;
`endif
      end else begin
         state <= state_nxt;
         wr_q  <= WR;
`ifdef READY_WAIT_EN
         cnt   <= cnt_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
`ifdef READY_WAIT_EN
      cnt_nxt   = cnt;
`endif
      if (ALE) begin
         // A new address phase always restarts the cycle, even mid-transfer.
         state_nxt = hit ? ST_ADDR : ST_IDLE;
`ifdef READY_WAIT_EN
         cnt_nxt   = 4'd0;
`endif
      end else begin
         case (state)
            ST_ADDR: begin
               if (both_low)
                  state_nxt = ST_IDLE;
               else if (rd_act || wr_act) begin
`ifdef READY_WAIT_EN
                  state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
                  cnt_nxt   = 4'd0;
`else
                  state_nxt = ST_DATA;
`endif
               end
            end
`ifdef READY_WAIT_EN
            ST_WAIT: begin
               if (both_low) begin
                  state_nxt = ST_IDLE;
                  cnt_nxt   = 4'd0;
               end else if (cnt == 4'(WAIT_STATES - 1)) begin
                  state_nxt = ST_DATA;
                  cnt_nxt   = 4'd0;
               end else
                  cnt_nxt = cnt + 4'd1;
            end
`endif
            ST_DATA: begin
               if (both_low || bus_idle)
                  state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Stage p0: address offset and write data capture
   always_ff @(posedge CLK) begin
      if (ALE)
         off_p0 <= bus_addr[ADDR_BITS-1:0];
      if (!WR && state != ST_IDLE)
         wdat_p0 <= AD;
   end

   // The write commits on the trailing edge of WR, using the last sampled data.
   assign ram_we = (state == ST_DATA) && !ALE && bus_idle && !wr_q;

   always_ff @(posedge CLK) begin
      if (ram_we)
         ram[off_p0] <= wdat_p0;
   end

   assign rd_drive = (state == ST_DATA) && rd_act;
   assign AD       = rd_drive ? ram[off_p0] : 8'hzz;
   assign SEL      = (state != ST_IDLE);

`ifdef READY_WAIT_EN
   assign READY = (state != ST_WAIT);
`else
   assign READY = 1'b1;
`endif

endmodule

// File: tb/tb_i8088_bus_responder.sv
// Directed bench for i8088_bus_responder: bus-cycle tasks with a read-data scoreboard queue.
// Expected wait count follows READY_WAIT_EN (WAIT_STATES = 2 when enabled).
module tb_i8088_bus_responder;

   logic        CLK = 1'b0;
   logic        RESET, ALE, IOM, RD, WR;
   logic [11:0] A;
   wire  [7:0]  AD;
   logic [7:0]  tb_ad;
   logic        tb_ad_en;
   logic        READY, SEL;

   int          compared   = 0;
   int          mismatched = 0;
   logic [7:0]  exp_q[$];

`ifdef READY_WAIT_EN
   localparam int EXP_WAIT = 2;
`else
   localparam int EXP_WAIT = 0;
`endif

   assign AD = tb_ad_en ? tb_ad : 8'hzz;

   i8088_bus_responder #(
      .IS_IO(0), .BASE_ADDR(20'h0), .ADDR_BITS(10), .WAIT_STATES(2)
   ) dut (
      .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR),
      .A(A), .AD(AD), .READY(READY), .SEL(SEL)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // An undriven bus may read as z, or as all-0/all-1 in a two-state simulator.
   task automatic chk_rel(input string tag);
      compared++;
      assert (AD === 8'hzz || AD === 8'h00 || AD === 8'hFF) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=released", tag, AD);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (READY !== 1'b1 && n < 20) begin
         n++;
         tick();
      end
   endtask

   task automatic addr_phase(input logic [19:0] a, input logic io);
      ALE      = 1'b1;
      IOM      = io;
      A        = a[19:8];
      tb_ad    = a[7:0];
      tb_ad_en = 1'b1;
      tick();
      ALE      = 1'b0;
   endtask

   task automatic bus_write(input string tag, input logic [19:0] a, input logic [7:0] d,
                            input logic io, input logic claim);
      int n;
      addr_phase(a, io);
      chk({tag, "_sel_addr"}, {7'd0, SEL}, {7'd0, claim});
      tb_ad = d;
      WR    = 1'b0;
      tick();
      wait_ready(n);
      chk({tag, "_wait"}, n[7:0], claim ? 8'(EXP_WAIT) : 8'd0);
      chk({tag, "_sel_data"}, {7'd0, SEL}, {7'd0, claim});
      WR = 1'b1;
      tick();
      tb_ad_en = 1'b0;
      chk({tag, "_sel_end"}, {7'd0, SEL}, 8'd0);
   endtask

   task automatic bus_read(input string tag, input logic [19:0] a, input logic io,
                           input logic claim, input logic [7:0] d);
      int n;
      addr_phase(a, io);
      tb_ad_en = 1'b0;
      RD       = 1'b0;
      if (claim) exp_q.push_back(d);
      tick();
      wait_ready(n);
      chk({tag, "_wait"}, n[7:0], claim ? 8'(EXP_WAIT) : 8'd0);
      if (claim) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
         end else
            chk({tag, "_data"}, AD, exp_q.pop_front());
      end else begin
         chk_rel({tag, "_nodrive"});
         chk({tag, "_sel"}, {7'd0, SEL}, 8'd0);
      end
      RD = 1'b1;
      #1;
      chk_rel({tag, "_release"});
      tick();
      chk({tag, "_sel_end"}, {7'd0, SEL}, 8'd0);
   endtask

   initial begin
      int n;
      RESET = 1'b1; ALE = 1'b0; IOM = 1'b0; RD = 1'b1; WR = 1'b1;
      A = 12'h0; tb_ad = 8'h00; tb_ad_en = 1'b0;
      #1;
      chk("rst_ready", {7'd0, READY}, 8'd1);
      chk("rst_sel", {7'd0, SEL}, 8'd0);
      chk_rel("rst_ad");
      tick(); tick();
      RESET = 1'b0;
      tick();

      // Basic write then read-back
      bus_write("w5", 20'h00005, 8'hA5, 1'b0, 1'b1);
      bus_read("r5", 20'h00005, 1'b0, 1'b1, 8'hA5);

      // Outside the window (offset 5 aliases a populated byte)
      bus_read("r405", 20'h00405, 1'b0, 1'b0, 8'h00);
      bus_read("r400", 20'h00400, 1'b0, 1'b0, 8'h00);

      // IO cycle must be ignored by a memory responder
      bus_write("io5", 20'h00005, 8'h3C, 1'b1, 1'b0);
      bus_read("r5_io", 20'h00005, 1'b0, 1'b1, 8'hA5);

      // Window edges
      bus_write("w3ff", 20'h003FF, 8'h5A, 1'b0, 1'b1);
      bus_write("w000", 20'h00000, 8'hC3, 1'b0, 1'b1);
      bus_read("r3ff", 20'h003FF, 1'b0, 1'b1, 8'h5A);
      bus_read("r000", 20'h00000, 1'b0, 1'b1, 8'hC3);

      // RD and WR low together abort the cycle
      bus_write("w10", 20'h00010, 8'h77, 1'b0, 1'b1);
      addr_phase(20'h00010, 1'b0);
      tb_ad_en = 1'b0;
      chk("ill_sel_addr", {7'd0, SEL}, 8'd1);
      RD = 1'b0; WR = 1'b0;
      tick();
      chk("ill_sel", {7'd0, SEL}, 8'd0);
      chk("ill_ready", {7'd0, READY}, 8'd1);
      chk_rel("ill_ad");
      RD = 1'b1; WR = 1'b1;
      tick();
      bus_read("r10", 20'h00010, 1'b0, 1'b1, 8'h77);

      // Reset in the middle of a read
      addr_phase(20'h00005, 1'b0);
      tb_ad_en = 1'b0;
      RD = 1'b0;
      tick();
      #2 RESET = 1'b1;
      #1;
      chk("rrst_ready", {7'd0, READY}, 8'd1);
      chk("rrst_sel", {7'd0, SEL}, 8'd0);
      chk_rel("rrst_ad");
      RD = 1'b1;
      tick();
      RESET = 1'b0;
      tick();
      bus_read("r5_rrst", 20'h00005, 1'b0, 1'b1, 8'hA5);

      // Reset in the middle of a write discards it
      addr_phase(20'h00005, 1'b0);
      tb_ad = 8'h11;
      WR    = 1'b0;
      tick();
      wait_ready(n);
      tick();
      #2 RESET = 1'b1;
      #1;
      chk("wrst_sel", {7'd0, SEL}, 8'd0);
      WR = 1'b1;
      tick();
      tb_ad_en = 1'b0;
      RESET = 1'b0;
      tick();
      bus_read("r5_wrst", 20'h00005, 1'b0, 1'b1, 8'hA5);

      chk("sb_empty", 8'(exp_q.size()), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
